irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NSRC, default 4, meaning the number of event sources (2..8).
REQ-002 SHALL have parameter DEPTH, default 4, meaning the event FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port src_req, input, NSRC bits: one-cycle event strobe per source.
REQ-006 SHALL have port src_data, input, 8*NSRC bits: event payload; source i uses bits [8i+7:8i].
REQ-007 SHALL have port src_busy, output, NSRC bits: source i pending slot occupied.
REQ-008 SHALL have port irr, output, 1 bit: interrupt request to the CPU; high while the FIFO is non-empty.
REQ-009 SHALL have port r_data, output, 8 bits: payload of the FIFO head.
REQ-010 SHALL have port r_src, output, 3 bits: source index of the FIFO head.
REQ-011 SHALL have port ack, input, 1 bit: CPU acknowledge, level, may stay high for several cycles.
REQ-012 SHALL have port ovf, output, NSRC bits: sticky per-source drop flag.
REQ-013 SHALL have port ovf_clr, input, 1 bit: clears all ovf bits.

Function
REQ-014 SHALL capture src_req[i] and its payload into pending slot i at the rising edge; src_busy[i] equals the registered pending[i].
REQ-015 SHALL, when src_req[i] arrives while pending[i] is set and slot i is not granted that cycle, drop the new event, keep the old payload, and set ovf[i].
REQ-016 SHALL, when src_req[i] arrives in the same cycle slot i is granted, accept the new event (pending[i] stays 1, new payload) without setting ovf[i].
REQ-017 SHALL grant one pending slot per cycle by round-robin: search starts at rr_ptr and wraps modulo NSRC; after a grant of i, rr_ptr becomes (i+1) mod NSRC.
REQ-018 SHALL grant only when the FIFO is not full or a pop occurs in the same cycle; a granted slot is cleared and {i, payload} is pushed at the same edge.
REQ-019 SHALL give latency: src_req sampled at edge E makes irr high after edge E+1 (empty FIFO, no competing sources).
REQ-020 SHALL pop the FIFO only on the rising edge of ack (ack high, registered ack_d low); a held ack SHALL pop exactly one entry.
REQ-021 SHALL ignore an ack rising edge when the FIFO is empty, with no state change.
REQ-022 SHALL drive r_data and r_src from the head entry combinationally; both read 0 when empty.
REQ-023 SHALL support simultaneous push and pop with the count unchanged; read and write pointers wrap modulo DEPTH.
REQ-024 SHALL give ovf_clr priority below same-cycle setting: a bit set and cleared in one cycle ends at 1.
REQ-025 SHALL keep irr combinational from the registered count (count != 0), with no path from src_req.

Reset
REQ-026 SHALL, while reset is low, asynchronously clear: pending, payload slots, FIFO pointers and count, rr_ptr=0, ack_d=0, ovf=0; outputs irr=0, r_data=0, r_src=0, src_busy=0.
REQ-027 SHALL discard all queued and pending events when reset is asserted mid-operation; the first edge after release behaves as from empty.

Verification
REQ-028 Single event: src_req[2] with 0x5A at edge 1 -> src_busy[2]=1 after edge 1; irr=1, r_src=2, r_data=0x5A after edge 2; ack 0->1 held 5 cycles -> exactly one pop, irr=0.
REQ-029 Round-robin: sources 0,1,3 strobe in the same cycle -> FIFO order r_src 0,1,3; next simultaneous 0 and 1 strobes -> order 0,1 (rr_ptr=0 after wrapping from 3).
REQ-030 Full FIFO: 4 events queued, no ack, source 1 strobes twice -> first stays pending (src_busy[1]=1), second sets ovf[1]=1, and ovf_clr -> ovf=0.
REQ-031 Full plus pop: FIFO full, slot 0 pending, ack rising edge -> same edge pops head and pushes slot 0, count stays 4.
REQ-032 Grant-and-refill: src_req[0] asserted in the cycle slot 0 is granted -> new payload pending, ovf[0]=0; ack with empty FIFO -> no change.
REQ-033 Reset mid-operation: 3 queued, 2 pending, reset low one cycle -> all outputs 0 immediately, and a later event sees 2-edge latency.

Source files
------------

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-source pending slots, a round-robin grant into an event FIFO,
// and a CPU-side interface that pops on the rising edge of ack.
module irq_ctrl #(
  parameter int unsigned NSRC  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   src_req,
  input  logic [8*NSRC-1:0] src_data,
  output logic [NSRC-1:0]   src_busy,
  output logic              irr,
  output logic [7:0]        r_data,
  output logic [2:0]        r_src,
  input  logic              ack,
  output logic [NSRC-1:0]   ovf,
  input  logic              ovf_clr
);

  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0] src;
    logic [7:0] data;
  } entry_t;

  logic [NSRC-1:0]        pend_q, pend_d;
  logic [NSRC-1:0][7:0]   slot_q, slot_d;
  logic [NSRC-1:0]        ovf_q, ovf_d;
  logic [2:0]             rr_q, rr_d;
  logic                   ack_q;
  entry_t [DEPTH-1:0]     mem_q;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [PW:0]            cnt_q;

  logic                   pop, full, can_push, gnt_vld, push;
  logic [2:0]             gnt_idx;
  logic [NSRC-1:0]        gnt_oh;
  logic [7:0]             push_data;
  int unsigned            best, off;
  entry_t                 head;

  assign full     = (cnt_q == (PW+1)'(DEPTH));
  assign pop      = ack && !ack_q && (cnt_q != '0);
  assign can_push = !full || pop;
  assign push     = gnt_vld && can_push;

  // Round-robin arbiter: pick the pending slot closest (modulo NSRC) at or after rr_q.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    best    = NSRC;
    off     = 0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (pend_q[i]) begin
        off = (i + NSRC - 32'(rr_q)) % NSRC;
        if (off < best) begin
          best    = off;
          gnt_vld = 1'b1;
          gnt_idx = 3'(i);
        end
      end
    end
  end

  // Decode the grant into a one-hot mask and select the payload being pushed.
  always_comb begin
    gnt_oh    = '0;
    push_data = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (push && (gnt_idx == 3'(i))) begin
        gnt_oh[i] = 1'b1;
        push_data = slot_q[i];
      end
    end
    rr_d = rr_q;
    if (push) begin
      rr_d = (gnt_idx == 3'(NSRC-1)) ? '0 : gnt_idx + 3'd1;
    end
  end

  // Pending slot update: a strobe refills a granted slot, but is dropped (and flagged) on an occupied one.
  // ovf_clr is applied first so a same-cycle drop still leaves the flag set.
  always_comb begin
    pend_d = pend_q;
    slot_d = slot_q;
    ovf_d  = ovf_clr ? '0 : ovf_q;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (gnt_oh[i]) begin
        pend_d[i] = 1'b0;
      end
      if (src_req[i]) begin
        if (!pend_q[i] || gnt_oh[i]) begin
          pend_d[i] = 1'b1;
          slot_d[i] = src_data[8*i +: 8];
        end else begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // Slot, overflow, arbiter pointer and ack-edge registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q <= '0;
      slot_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      ack_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      slot_q <= slot_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      ack_q  <= ack;
    end
  end

  // Event FIFO storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= '{src: gnt_idx, data: push_data};
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign head     = mem_q[rptr_q];
  assign irr      = (cnt_q != '0);
  assign r_data   = irr ? head.data : '0;
  assign r_src    = irr ? head.src  : '0;
  assign src_busy = pend_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: table of single-event vectors plus hand-written
// sequences, with a queue of expected FIFO heads.
module tb_irq_ctrl;

  logic        clk;
  logic        reset;
  logic [3:0]  src_req;
  logic [31:0] src_data;
  logic [3:0]  src_busy;
  logic        irr;
  logic [7:0]  r_data;
  logic [2:0]  r_src;
  logic        ack;
  logic [3:0]  ovf;
  logic        ovf_clr;

  int errors   = 0;
  int n_checks = 0;

  typedef struct {
    logic [2:0] src;
    logic [7:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int         src;
    logic [7:0] data;
    logic [3:0] exp_busy;
    logic [2:0] exp_src;
    logic [7:0] exp_data;
  } vec_t;
  vec_t tbl[4];

  irq_ctrl #(.NSRC(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_req  (src_req),
    .src_data (src_data),
    .src_busy (src_busy),
    .irr      (irr),
    .r_data   (r_data),
    .r_src    (r_src),
    .ack      (ack),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] m, input logic [31:0] d);
    src_req  = m;
    src_data = d;
    tick();
    src_req  = '0;
  endtask

  task automatic sb_push(input logic [2:0] s, input logic [7:0] d);
    exp_t e;
    e.src  = s;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic check_head();
    exp_t e;
    if (sbq.size() == 0) begin
      n_checks++;
      errors++;
      $display("FAIL sb_empty: got no expected entry, required one");
    end else begin
      e = sbq.pop_front();
      chk("head_irr", 32'(irr), 32'd1);
      chk("head_src", 32'(r_src), 32'(e.src));
      chk("head_data", 32'(r_data), 32'(e.data));
    end
  endtask

  task automatic pop_check();
    check_head();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
  endtask

  initial begin
    tbl[0] = '{src: 0, data: 8'h11, exp_busy: 4'b0001, exp_src: 3'd0, exp_data: 8'h11};
    tbl[1] = '{src: 1, data: 8'h00, exp_busy: 4'b0010, exp_src: 3'd1, exp_data: 8'h00};
    tbl[2] = '{src: 2, data: 8'hA5, exp_busy: 4'b0100, exp_src: 3'd2, exp_data: 8'hA5};
    tbl[3] = '{src: 3, data: 8'hFF, exp_busy: 4'b1000, exp_src: 3'd3, exp_data: 8'hFF};

    reset = 1'b0; src_req = '0; src_data = '0; ack = 1'b0; ovf_clr = 1'b0;
    #3;
    chk("rst_irr", 32'(irr), 0);
    chk("rst_busy", 32'(src_busy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_rdata", 32'(r_data), 0);
    chk("rst_rsrc", 32'(r_src), 0);
    tick();
    reset = 1'b1;

    // single event with a held ack
    strobe(4'b0100, 32'h005A_0000);
    chk("single_busy", 32'(src_busy), 32'h4);
    chk("single_irr_lat", 32'(irr), 0);
    sb_push(3'd2, 8'h5A);
    tick();
    chk("single_busy_clr", 32'(src_busy), 0);
    check_head();
    ack = 1'b1;
    tick();
    chk("held_ack_pop1", 32'(irr), 0);
    repeat (4) tick();
    chk("held_ack_pop5", 32'(irr), 0);
    chk("held_ack_rdata", 32'(r_data), 0);
    ack = 1'b0;
    tick();

    // table of single-source events; leaves the arbiter pointer back at 0
    for (int v = 0; v < 4; v++) begin
      logic [31:0] d;
      d = 32'(tbl[v].data) << (8 * tbl[v].src);
      strobe(4'(1 << tbl[v].src), d);
      chk("tbl_busy", 32'(src_busy), 32'(tbl[v].exp_busy));
      chk("tbl_lat", 32'(irr), 0);
      tick();
      chk("tbl_irr", 32'(irr), 1);
      chk("tbl_src", 32'(r_src), 32'(tbl[v].exp_src));
      chk("tbl_data", 32'(r_data), 32'(tbl[v].exp_data));
      ack = 1'b1; tick(); ack = 1'b0; tick();
      chk("tbl_empty", 32'(irr), 0);
    end

    // round robin from pointer 0, then after wrap
    strobe(4'b1011, 32'hA3_00_A1_A0);
    sb_push(3'd0, 8'hA0); sb_push(3'd1, 8'hA1); sb_push(3'd3, 8'hA3);
    tick();
    pop_check(); pop_check(); pop_check();
    chk("rr_drained", 32'(irr), 0);
    strobe(4'b0011, 32'h0000_B1B0);
    sb_push(3'd0, 8'hB0); sb_push(3'd1, 8'hB1);
    tick();
    pop_check(); pop_check();

    // round robin starting mid-way: after a grant of 1, sources 0 and 3 go 3 then 0
    strobe(4'b0010, 32'h0000_2100);
    sb_push(3'd1, 8'h21);
    tick();
    pop_check();
    strobe(4'b1001, 32'h3300_0030);
    sb_push(3'd3, 8'h33); sb_push(3'd0, 8'h30);
    tick();
    pop_check(); pop_check();
    chk("rr2_drained", 32'(irr), 0);

    // fill the FIFO (pointer now 1 -> order 1,2,3,0)
    strobe(4'b1111, 32'hB3B2_B1B0);
    sb_push(3'd1, 8'hB1); sb_push(3'd2, 8'hB2); sb_push(3'd3, 8'hB3); sb_push(3'd0, 8'hB0);
    repeat (4) tick();
    chk("full_busy0", 32'(src_busy), 0);
    strobe(4'b0010, 32'h0000_C100);
    chk("full_pend", 32'(src_busy), 32'h2);
    chk("full_ovf0", 32'(ovf), 0);
    strobe(4'b0010, 32'h0000_C200);
    chk("full_ovf", 32'(ovf), 32'h2);
    chk("full_pend2", 32'(src_busy), 32'h2);
    chk("full_head_src", 32'(r_src), 1);
    chk("full_head_data", 32'(r_data), 32'hB1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 0);
    ovf_clr = 1'b1;
    strobe(4'b0010, 32'h0000_C300);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(ovf), 32'h2);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr2", 32'(ovf), 0);

    // full FIFO: pop and grant of the pending slot on the same edge
    pop_check();
    sb_push(3'd1, 8'hC1);
    chk("fullpop_busy", 32'(src_busy), 0);
    chk("fullpop_head", 32'(r_src), 2);
    strobe(4'b1000, 32'hD300_0000);
    chk("fullpop_still_full", 32'(src_busy), 32'h8);
    sb_push(3'd3, 8'hD3);
    repeat (5) pop_check();
    chk("drain_irr", 32'(irr), 0);
    chk("drain_busy", 32'(src_busy), 0);

    // grant-and-refill on slot 0
    strobe(4'b0001, 32'h0000_00E0);
    src_req = 4'b0001; src_data = 32'h0000_00E1;
    tick();
    src_req = '0;
    sb_push(3'd0, 8'hE0); sb_push(3'd0, 8'hE1);
    chk("refill_busy", 32'(src_busy), 32'h1);
    chk("refill_ovf", 32'(ovf), 0);
    pop_check(); pop_check();
    ack = 1'b1; tick(); ack = 1'b0; tick();
    chk("empty_ack_irr", 32'(irr), 0);
    chk("empty_ack_busy", 32'(src_busy), 0);
    chk("empty_ack_data", 32'(r_data), 0);

    // reset mid-operation with 3 queued and 2 pending
    strobe(4'b1110, 32'hF3F2_F100);
    repeat (3) tick();
    strobe(4'b0011, 32'h0000_0201);
    chk("pre_rst_busy", 32'(src_busy), 32'h3);
    chk("pre_rst_irr", 32'(irr), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_irr", 32'(irr), 0);
    chk("mid_rst_busy", 32'(src_busy), 0);
    chk("mid_rst_rsrc", 32'(r_src), 0);
    chk("mid_rst_rdata", 32'(r_data), 0);
    sbq.delete();
    tick();
    reset = 1'b1;
    chk("post_rst_irr", 32'(irr), 0);
    strobe(4'b1000, 32'h7700_0000);
    chk("post_rst_lat", 32'(irr), 0);
    chk("post_rst_busy", 32'(src_busy), 32'h8);
    sb_push(3'd3, 8'h77);
    tick();
    pop_check();
    chk("final_irr", 32'(irr), 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
